muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_if.sv | 27 ++
 rtl/muldiv_unit.sv | 144 ++++++++++++++
 tb/tb_muldiv_unit.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the
// iterative multiply/divide unit.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic               start_i;
   logic [1:0]         op_i;
   logic [WIDTH-1:0]   opdata1_i;
   logic [WIDTH-1:0]   opdata2_i;
   logic               annul_i;
   logic [2*WIDTH-1:0] result_o;
   logic               ready_o;
   logic               busy_o;
   logic               dz_o;

   modport master (
      output start_i, op_i, opdata1_i,
      output opdata2_i, annul_i,
      input  result_o, ready_o, busy_o, dz_o
   );

   modport slave (
      input  start_i, op_i, opdata1_i,
      input  opdata2_i, annul_i,
      output result_o, ready_o, busy_o, dz_o
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle.
module muldiv_unit #(
   parameter int WIDTH         = 32,
   parameter int SIGNED_DIV_EN = 1
) (
   input logic         clk,
   input logic         rst,
   muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int W2 = 2 * WIDTH;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] BYZERO = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic             is_div;
   logic             neg_q;
   logic             neg_r;
   logic             dz_q;
   logic [WIDTH-1:0] opa;
   logic [W2-1:0]    acc;
   logic [W2-1:0]    result_q;

   logic             accept;
   logic             signed_op;
   logic             neg1;
   logic             neg2;
   logic             div0;
   logic [WIDTH-1:0] mag1;
   logic [WIDTH-1:0] mag2;

   assign accept = (state == IDLE) && bus.start_i
                && !bus.annul_i;

   assign signed_op = (bus.op_i == 2'b00)
                   || ((bus.op_i == 2'b10)
                       && (SIGNED_DIV_EN != 0));

   assign neg1 = signed_op && bus.opdata1_i[WIDTH-1];
   assign neg2 = signed_op && bus.opdata2_i[WIDTH-1];
   assign mag1 = neg1 ? -bus.opdata1_i : bus.opdata1_i;
   assign mag2 = neg2 ? -bus.opdata2_i : bus.opdata2_i;
   assign div0 = bus.op_i[1] && (bus.opdata2_i == '0);

   // acc = {hi, lo}: product accumulator, or {remainder, dividend/quotient}
   logic [WIDTH:0]   mul_sum;
   logic [W2-1:0]    mul_nxt;
   logic [WIDTH:0]   div_trial;
   logic [WIDTH+1:0] div_diff;
   logic             borrow;
   logic [W2-1:0]    div_nxt;
   logic [W2-1:0]    step;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;
   logic [W2-1:0]    mul_fin;
   logic [W2-1:0]    div_fin;
   logic [W2-1:0]    fin;
   logic             last;

   assign mul_sum = {1'b0, acc[W2-1:WIDTH]}
                  + (acc[0] ? {1'b0, opa}
                            : {(WIDTH+1){1'b0}});
   assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

   assign div_trial = {acc[W2-1:WIDTH], acc[WIDTH-1]};
   assign div_diff  = {1'b0, div_trial} - {2'b00, opa};
   assign borrow    = div_diff[WIDTH+1];
   assign div_nxt   = borrow
      ? {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
      : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

   assign step    = is_div ? div_nxt : mul_nxt;
   assign step_hi = step[W2-1:WIDTH];
   assign step_lo = step[WIDTH-1:0];

   assign mul_fin = neg_q ? -step : step;
   assign div_fin = {neg_r ? -step_hi : step_hi,
                     neg_q ? -step_lo : step_lo};
   assign fin     = is_div ? div_fin : mul_fin;

   assign last = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         dz_q     <= 1'b0;
         opa      <= '0;
         acc      <= '0;
         result_q <= '0;
      end else begin
         unique case (1'b1)
            (state == IDLE): begin
               if (accept) begin
                  cnt      <= '0;
                  result_q <= '0;
                  is_div   <= bus.op_i[1];
                  neg_q    <= neg1 ^ neg2;
                  neg_r    <= neg1;
                  dz_q     <= div0;
                  opa      <= bus.op_i[1] ? mag2 : mag1;
                  acc      <= {{WIDTH{1'b0}},
                               bus.op_i[1] ? mag1 : mag2};
                  state    <= div0 ? BYZERO : RUN;
               end
            end
            (state == RUN): begin
               if (bus.annul_i) begin
                  result_q <= '0;
                  state    <= IDLE;
               end else begin
                  acc <= step;
                  cnt <= cnt + CW'(1);
                  if (last) begin
                     result_q <= fin;
                     state    <= DONE;
                  end
               end
            end
            (state == BYZERO): begin
               result_q <= '0;
               state    <= bus.annul_i ? IDLE : DONE;
            end
            (state == DONE): begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.result_o = result_q;
   assign bus.ready_o  = (state == DONE);
   assign bus.busy_o   = (state != IDLE);
   assign bus.dz_o     = (state == DONE) && dz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against a
// 64-bit arithmetic reference model.
module tb_muldiv_unit;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;

   muldiv_unit_if #(.WIDTH(W)) bus();

   muldiv_unit #(
      .WIDTH(W),
      .SIGNED_DIV_EN(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(
      input logic [1:0] op,
      input logic [31:0] a,
      input logic [31:0] b,
      output logic dz);
      longint sa;
      longint sb;
      longint q;
      longint r;
      logic [63:0] p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      dz = 1'b0;
      p  = '0;
      case (op)
         2'b00: p = sa * sb;
         2'b01: p = {32'b0, a} * {32'b0, b};
         2'b10: begin
            if (b == 0) dz = 1'b1;
            else begin
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 0) dz = 1'b1;
            else p = {a % b, a / b};
         end
      endcase
      return p;
   endfunction

   task automatic drive(input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
      bus.op_i      = op;
      bus.opdata1_i = a;
      bus.opdata2_i = b;
   endtask

   // Leaves the bench 1 ns into cycle k+1
   task automatic go(input logic [1:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b);
      @(negedge clk);
      bus.start_i = 1'b1;
      drive(op, a, b);
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      chk("busy_k1", bus.busy_o, 1);
      chk("clear_k1", bus.result_o, 0);
      chk("ready_k1", bus.ready_o, 0);
   endtask

   task automatic finish_op(input logic [1:0] op,
                            input logic [31:0] a,
                            input logic [31:0] b,
                            input bit hold_start,
                            output logic [63:0] res);
      logic exp_dz;
      logic [63:0] exp;
      int lat;
      int c;
      bit ok;
      exp = model(op, a, b, exp_dz);
      lat = (op[1] && b == 0) ? 2 : W + 1;
      c = 1;
      ok = 1'b1;
      while (!bus.ready_o && c < 200) begin
         if (!bus.busy_o || bus.dz_o) ok = 1'b0;
         @(posedge clk);
         #1;
         c++;
      end
      chk("latency", c, lat);
      chk("busy_run", ok, 1);
      chk("result", bus.result_o, exp);
      chk("dz", bus.dz_o, exp_dz);
      chk("busy_done", bus.busy_o, 1);
      res = bus.result_o;
      if (hold_start) begin
         bus.start_i = 1'b1;
         drive(2'b01, 32'h1234, 32'h5678);
      end
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      chk("ready_pulse", bus.ready_o, 0);
      chk("idle", bus.busy_o, 0);
      chk("dz_low", bus.dz_o, 0);
      chk("hold", bus.result_o, exp);
   endtask

   task automatic annul_at(input int j);
      bit ok;
      ok = 1'b1;
      for (int i = 1; i < j; i++) begin
         @(posedge clk);
         #1;
         if (bus.ready_o) ok = 1'b0;
      end
      bus.annul_i = 1'b1;
      @(posedge clk);
      #1;
      bus.annul_i = 1'b0;
      chk("annul_noready", ok, 1);
      chk("annul_busy", bus.busy_o, 0);
      chk("annul_ready", bus.ready_o, 0);
      chk("annul_result", bus.result_o, 0);
      chk("annul_dz", bus.dz_o, 0);
   endtask

   initial begin
      logic [63:0] res;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int lat;

      bus.start_i = 1'b0;
      bus.annul_i = 1'b0;
      drive(2'b00, 0, 0);
      #1;
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_ready", bus.ready_o, 0);
      chk("rst_dz", bus.dz_o, 0);
      chk("rst_result", bus.result_o, 0);
      @(negedge clk);
      rst = 1'b1;

      go(2'b00, 32'hFFFFFFFD, 32'd5);
      finish_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b1, res);
      chk("mult_m3x5", res, 64'hFFFFFFFF_FFFFFFF1);

      go(2'b11, 32'd100, 32'd7);
      finish_op(2'b11, 32'd100, 32'd7, 1'b0, res);
      chk("divu_100_7", res, 64'h00000002_0000000E);

      go(2'b10, 32'hFFFFFFF9, 32'd2);
      finish_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, res);
      chk("div_m7_2", res, 64'hFFFFFFFF_FFFFFFFD);

      go(2'b10, 32'h80000000, 32'hFFFFFFFF);
      finish_op(2'b10, 32'h80000000, 32'hFFFFFFFF,
                1'b0, res);
      chk("div_ovf", res, 64'h00000000_80000000);

      go(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      finish_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
                1'b1, res);
      chk("multu_max", res, 64'hFFFFFFFE_00000001);

      go(2'b11, 32'd5, 32'd0);
      chk("byzero_dz", bus.dz_o, 0);
      finish_op(2'b11, 32'd5, 32'd0, 1'b0, res);
      chk("divu_5_0", res, 64'h0);

      go(2'b00, 32'd77, 32'd91);
      annul_at(10);
      go(2'b11, 32'd9, 32'd3);
      finish_op(2'b11, 32'd9, 32'd3, 1'b0, res);
      chk("divu_9_3", res, 64'h00000000_00000003);

      go(2'b10, 32'd5, 32'd0);
      annul_at(1);

      @(negedge clk);
      bus.start_i = 1'b1;
      bus.annul_i = 1'b1;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      bus.annul_i = 1'b0;
      chk("idle_annul", bus.busy_o, 0);

      go(2'b01, 32'd3, 32'd4);
      finish_op(2'b01, 32'd3, 32'd4, 1'b0, res);
      #3;
      rst = 1'b0;
      #1;
      chk("rst_idle_result", bus.result_o, 0);
      @(negedge clk);
      rst = 1'b1;

      go(2'b00, 32'hFFFFFFFD, 32'd5);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      #3;
      rst = 1'b0;
      #1;
      chk("rst_mid_busy", bus.busy_o, 0);
      chk("rst_mid_ready", bus.ready_o, 0);
      chk("rst_mid_dz", bus.dz_o, 0);
      chk("rst_mid_result", bus.result_o, 0);
      bus.start_i = 1'b1;
      drive(2'b11, 32'd100, 32'd7);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      chk("rst_accept", bus.busy_o, 1);
      finish_op(2'b11, 32'd100, 32'd7, 1'b0, res);

      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0)
            b = $urandom_range(0, 15);
         if ($urandom_range(0, 5) == 0) b = 0;
         if ($urandom_range(0, 7) == 0) a = 32'h80000000;
         if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
         go(op, a, b);
         lat = (op[1] && b == 0) ? 2 : W + 1;
         if ($urandom_range(0, 6) == 0)
            annul_at($urandom_range(1, lat - 1));
         else
            finish_op(op, a, b,
                      1'($urandom_range(0, 1)), res);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
